csr_priv_guard: RTL and testbench

- Registered privilege guard for CSR/MMIO accesses; replaces ad-hoc single-compare checks with NUM_RANGES programmable protected address windows.
- Sits between the decode stage and the CSR file.
- Every access is checked, with no exemptions. Unmatched addresses default to machine-only.
- Valid/ready request and response handshakes, lockable range configuration, and a sticky violation log.

---
 rtl/csr_guard_pkg.sv | 56 +++++
 rtl/csr_range_match.sv | 39 +++
 rtl/csr_priv_guard.sv | 208 ++++++++++++++++++++
 tb/tb_csr_priv_guard.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_guard_pkg.sv
// Shared types and the access decision rule for the CSR privilege guard.
package csr_guard_pkg;

  typedef enum logic [1:0] {
    PRIV_U    = 2'd0,
    PRIV_S    = 2'd1,
    PRIV_RSVD = 2'd2,
    PRIV_M    = 2'd3
  } priv_e;

  typedef enum logic [1:0] {
    CauseNone = 2'd0,
    CausePriv = 2'd1,
    CauseRo   = 2'd2,
    CauseRsvd = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StResp  = 2'd2
  } state_e;

  // Window bounds are stored at a fixed width; narrower addresses are zero-extended.
  localparam int unsigned CfgAddrW = 32;

  // Privilege required for any address not covered by an enabled window.
  localparam priv_e MACHINE_PRIV = PRIV_M;

  typedef struct packed {
    logic [CfgAddrW-1:0] base;
    logic [CfgAddrW-1:0] limit;
    priv_e               min_priv;
    logic                ro;
    logic                lock;
    logic                enabled;
  } range_cfg_t;

  localparam range_cfg_t RangeRst = '{
    base:     '0,
    limit:    '0,
    min_priv: MACHINE_PRIV,
    ro:       1'b0,
    lock:     1'b0,
    enabled:  1'b0
  };

  // Decision in priority order: reserved privilege, insufficient privilege, write to read-only.
  function automatic cause_e decide(priv_e priv, priv_e min_priv, logic write, logic ro);
    if (priv == PRIV_RSVD) return CauseRsvd;
    if (priv < min_priv)   return CausePriv;
    if (write && ro)       return CauseRo;
    return CauseNone;
  endfunction

endpackage

// File: rtl/csr_range_match.sv
// Window comparators with a lowest-index-wins priority encoder.
module csr_range_match
  import csr_guard_pkg::*;
#(
  parameter int unsigned NUM_RANGES = 4
) (
  input  logic [CfgAddrW-1:0]                 addr_i,
  input  logic [NUM_RANGES-1:0][CfgAddrW-1:0] base_i,
  input  logic [NUM_RANGES-1:0][CfgAddrW-1:0] limit_i,
  input  logic [NUM_RANGES-1:0][1:0]          min_priv_i,
  input  logic [NUM_RANGES-1:0]               ro_i,
  input  logic [NUM_RANGES-1:0]               en_i,
  output logic                                hit_o,
  output priv_e                               min_priv_o,
  output logic                                ro_o
);

  logic [NUM_RANGES-1:0] match;

  // A window with base > limit can never satisfy both bounds, so it never matches.
  for (genvar g = 0; g < NUM_RANGES; g++) begin : g_cmp
    assign match[g] = en_i[g] && (base_i[g] <= addr_i) && (addr_i <= limit_i[g]);
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_o      = 1'b0;
    min_priv_o = MACHINE_PRIV;
    ro_o       = 1'b0;
    for (int i = int'(NUM_RANGES) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o      = 1'b1;
        min_priv_o = priv_e'(min_priv_i[i]);
        ro_o       = ro_i[i];
      end
    end
  end

endmodule

// File: rtl/csr_priv_guard.sv
// Registered privilege guard for CSR/MMIO accesses with programmable protected windows,
// lockable configuration and a sticky violation log.
module csr_priv_guard
  import csr_guard_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned NUM_RANGES = 4,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned IDX_W     = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_priv_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_grant_o,
  output logic              rsp_exc_o,
  output logic [1:0]        rsp_cause_o,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [ADDR_W-1:0] cfg_limit_i,
  input  logic [1:0]        cfg_min_priv_i,
  input  logic              cfg_ro_i,
  input  logic              cfg_lock_i,
  input  logic              viol_clear_i,
  output logic              viol_valid_o,
  output logic [ADDR_W-1:0] viol_addr_o,
  output logic [CNT_W-1:0]  viol_cnt_o
);

  state_e state_q, state_d;
  logic   accept, check, rsp_hs;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  priv_e             priv_q;

  logic   grant_q, exc_q;
  cause_e cause_q, cause_d;

  range_cfg_t ranges_q [NUM_RANGES];
  range_cfg_t cfg_new;

  logic [NUM_RANGES-1:0][CfgAddrW-1:0] base_vec, limit_vec;
  logic [NUM_RANGES-1:0][1:0]          minp_vec;
  logic [NUM_RANGES-1:0]               ro_vec, en_vec;
  logic                                hit, match_ro, eff_ro;
  priv_e                               match_min, eff_min;

  logic              viol_valid_q;
  logic [ADDR_W-1:0] viol_addr_q;
  logic [CNT_W-1:0]  viol_cnt_q;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    check       = 1'b0;
    rsp_hs      = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        check   = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          rsp_hs  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture the request on acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      priv_q  <= PRIV_U;
    end else if (accept) begin
      addr_q  <= req_addr_i;
      write_q <= req_write_i;
      priv_q  <= priv_e'(req_priv_i);
    end
  end

  // Assemble the incoming window configuration
  always_comb begin
    cfg_new          = RangeRst;
    cfg_new.base     = CfgAddrW'(cfg_base_i);
    cfg_new.limit    = CfgAddrW'(cfg_limit_i);
    cfg_new.min_priv = priv_e'(cfg_min_priv_i);
    cfg_new.ro       = cfg_ro_i;
    cfg_new.lock     = cfg_lock_i;
    cfg_new.enabled  = 1'b1;
  end

  // Window registers; a locked window ignores writes until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_RANGES); i++) ranges_q[i] <= RangeRst;
    end else if (cfg_we_i) begin
      for (int i = 0; i < int'(NUM_RANGES); i++) begin
        if (cfg_idx_i == IDX_W'(i) && !ranges_q[i].lock) ranges_q[i] <= cfg_new;
      end
    end
  end

  // Flatten window fields for the comparator block
  always_comb begin
    for (int i = 0; i < int'(NUM_RANGES); i++) begin
      base_vec[i]  = ranges_q[i].base;
      limit_vec[i] = ranges_q[i].limit;
      minp_vec[i]  = ranges_q[i].min_priv;
      ro_vec[i]    = ranges_q[i].ro;
      en_vec[i]    = ranges_q[i].enabled;
    end
  end

  csr_range_match #(
    .NUM_RANGES (NUM_RANGES)
  ) u_match (
    .addr_i     (CfgAddrW'(addr_q)),
    .base_i     (base_vec),
    .limit_i    (limit_vec),
    .min_priv_i (minp_vec),
    .ro_i       (ro_vec),
    .en_i       (en_vec),
    .hit_o      (hit),
    .min_priv_o (match_min),
    .ro_o       (match_ro)
  );

  // Unmatched addresses are machine-only and never read-only
  always_comb begin
    eff_min = hit ? match_min : MACHINE_PRIV;
    eff_ro  = hit && match_ro;
    cause_d = decide(priv_q, eff_min, write_q, eff_ro);
  end

  // Register the decision in CHECK; held stable through RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= CauseNone;
    end else if (check) begin
      grant_q <= (cause_d == CauseNone);
      exc_q   <= (cause_d != CauseNone);
      cause_q <= cause_d;
    end
  end

  // Violation log; a violation handshake beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_valid_q <= 1'b0;
      viol_addr_q  <= '0;
      viol_cnt_q   <= '0;
    end else if (rsp_hs && exc_q) begin
      if (viol_clear_i) begin
        viol_cnt_q   <= CNT_W'(1);
        viol_valid_q <= 1'b1;
        viol_addr_q  <= addr_q;
      end else begin
        if (viol_cnt_q != {CNT_W{1'b1}}) viol_cnt_q <= viol_cnt_q + CNT_W'(1);
        if (!viol_valid_q) begin
          viol_valid_q <= 1'b1;
          viol_addr_q  <= addr_q;
        end
      end
    end else if (viol_clear_i) begin
      viol_cnt_q   <= '0;
      viol_valid_q <= 1'b0;
      viol_addr_q  <= '0;
    end
  end

  assign rsp_grant_o  = grant_q;
  assign rsp_exc_o    = exc_q;
  assign rsp_cause_o  = cause_q;
  assign viol_valid_o = viol_valid_q;
  assign viol_addr_o  = viol_addr_q;
  assign viol_cnt_o   = viol_cnt_q;

endmodule

// File: tb/tb_csr_priv_guard.sv
// Self-checking bench for csr_priv_guard: directed steps plus randomized accesses
// compared against a rule-level reference model.
module tb_csr_priv_guard;

  localparam int unsigned AW = 12;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [1:0]    req_priv_i;
  logic [AW-1:0] req_addr_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_grant_o, rsp_exc_o;
  logic [1:0]    rsp_cause_o;
  logic          cfg_we_i;
  logic [1:0]    cfg_idx_i;
  logic [AW-1:0] cfg_base_i, cfg_limit_i;
  logic [1:0]    cfg_min_priv_i;
  logic          cfg_ro_i, cfg_lock_i, viol_clear_i, viol_valid_o;
  logic [AW-1:0] viol_addr_o;
  logic [CW-1:0] viol_cnt_o;

  csr_priv_guard #(
    .ADDR_W     (AW),
    .NUM_RANGES (NR),
    .CNT_W      (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_write_i    (req_write_i),
    .req_priv_i     (req_priv_i),
    .req_addr_i     (req_addr_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_grant_o    (rsp_grant_o),
    .rsp_exc_o      (rsp_exc_o),
    .rsp_cause_o    (rsp_cause_o),
    .cfg_we_i       (cfg_we_i),
    .cfg_idx_i      (cfg_idx_i),
    .cfg_base_i     (cfg_base_i),
    .cfg_limit_i    (cfg_limit_i),
    .cfg_min_priv_i (cfg_min_priv_i),
    .cfg_ro_i       (cfg_ro_i),
    .cfg_lock_i     (cfg_lock_i),
    .viol_clear_i   (viol_clear_i),
    .viol_valid_o   (viol_valid_o),
    .viol_addr_o    (viol_addr_o),
    .viol_cnt_o     (viol_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_base [NR];
  int          m_limit[NR];
  int          m_minp [NR];
  bit          m_ro   [NR];
  bit          m_lock [NR];
  bit          m_en   [NR];
  int          m_cnt;
  bit          m_vvalid;
  int          m_vaddr;

  // Configuration staged for a write landing on the CHECK edge
  int mc_idx, mc_base, mc_limit, mc_minp;
  bit mc_ro, mc_lock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) begin
      m_base[i] = 0; m_limit[i] = 0; m_minp[i] = 3;
      m_ro[i] = 0; m_lock[i] = 0; m_en[i] = 0;
    end
    m_cnt = 0; m_vvalid = 0; m_vaddr = 0;
  endtask

  task automatic model_cfg(input int idx, input int b, input int l, input int mp,
                           input bit ro, input bit lk);
    if (!m_lock[idx]) begin
      m_base[idx] = b; m_limit[idx] = l; m_minp[idx] = mp;
      m_ro[idx] = ro; m_lock[idx] = lk; m_en[idx] = 1;
    end
  endtask

  function automatic int model_cause(input bit wr, input int pv, input int ad);
    int hit;
    int minp;
    bit ro;
    hit = -1; minp = 3; ro = 0;
    for (int i = 0; i < int'(NR); i++)
      if (hit < 0 && m_en[i] && m_base[i] <= ad && ad <= m_limit[i]) hit = i;
    if (hit >= 0) begin minp = m_minp[hit]; ro = m_ro[hit]; end
    if (pv == 2) return 3;
    if (pv < minp) return 1;
    if (wr && ro) return 2;
    return 0;
  endfunction

  task automatic cfg_write(input int idx, input int b, input int l, input int mp,
                           input bit ro, input bit lk);
    cfg_we_i = 1; cfg_idx_i = idx[1:0]; cfg_base_i = b[AW-1:0]; cfg_limit_i = l[AW-1:0];
    cfg_min_priv_i = mp[1:0]; cfg_ro_i = ro; cfg_lock_i = lk;
    @(posedge clk_i); #1;
    cfg_we_i = 0;
    model_cfg(idx, b, l, mp, ro, lk);
  endtask

  // One full transaction: accept, wait for the decision, hold, handshake, check the log.
  task automatic do_access(input bit wr, input int pv, input int ad, input int hold,
                           input bit clr, input bit mid_cfg);
    int exp_cause;
    int n;
    exp_cause = model_cause(wr, pv, ad);
    chk("req_ready_idle", {31'b0, req_ready_o}, 1);
    req_valid_i = 1; req_write_i = wr; req_priv_i = pv[1:0]; req_addr_i = ad[AW-1:0];
    @(posedge clk_i); #1;
    req_valid_i = 0; req_addr_i = AW'($urandom); req_write_i = ~wr; req_priv_i = 2'($urandom);
    chk("req_ready_busy", {31'b0, req_ready_o}, 0);
    chk("rsp_valid_early", {31'b0, rsp_valid_o}, 0);
    if (mid_cfg) begin
      cfg_we_i = 1; cfg_idx_i = mc_idx[1:0]; cfg_base_i = mc_base[AW-1:0];
      cfg_limit_i = mc_limit[AW-1:0]; cfg_min_priv_i = mc_minp[1:0];
      cfg_ro_i = mc_ro; cfg_lock_i = mc_lock;
    end
    n = 0;
    while (!rsp_valid_o && n < 8) begin
      @(posedge clk_i); #1;
      n++;
      if (mid_cfg && cfg_we_i) begin
        cfg_we_i = 0;
        model_cfg(mc_idx, mc_base, mc_limit, mc_minp, mc_ro, mc_lock);
      end
    end
    chk("rsp_latency", n, 1);
    chk("rsp_cause", {30'b0, rsp_cause_o}, exp_cause);
    chk("rsp_grant", {31'b0, rsp_grant_o}, (exp_cause == 0) ? 1 : 0);
    chk("rsp_exc", {31'b0, rsp_exc_o}, (exp_cause != 0) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      chk("hold_valid", {31'b0, rsp_valid_o}, 1);
      chk("hold_ready", {31'b0, req_ready_o}, 0);
      chk("hold_cause", {30'b0, rsp_cause_o}, exp_cause);
      chk("hold_grant", {31'b0, rsp_grant_o}, (exp_cause == 0) ? 1 : 0);
    end
    rsp_ready_i = 1; viol_clear_i = clr;
    @(posedge clk_i); #1;
    rsp_ready_i = 0; viol_clear_i = 0;
    if (exp_cause != 0) begin
      if (clr) begin
        m_cnt = 1; m_vvalid = 1; m_vaddr = ad;
      end else begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (!m_vvalid) begin m_vvalid = 1; m_vaddr = ad; end
      end
    end else if (clr) begin
      m_cnt = 0; m_vvalid = 0; m_vaddr = 0;
    end
    chk("rsp_valid_done", {31'b0, rsp_valid_o}, 0);
    chk("viol_cnt", {30'b0, viol_cnt_o}, m_cnt);
    chk("viol_valid", {31'b0, viol_valid_o}, m_vvalid);
    chk("viol_addr", {20'b0, viol_addr_o}, m_vaddr);
  endtask

  initial begin
    rst_ni = 0; req_valid_i = 0; req_write_i = 0; req_priv_i = 0; req_addr_i = 0;
    rsp_ready_i = 0; cfg_we_i = 0; cfg_idx_i = 0; cfg_base_i = 0; cfg_limit_i = 0;
    cfg_min_priv_i = 0; cfg_ro_i = 0; cfg_lock_i = 0; viol_clear_i = 0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1;
    @(posedge clk_i); #1;

    // Reset values
    chk("rst_req_ready", {31'b0, req_ready_o}, 1);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 0);
    chk("rst_grant", {31'b0, rsp_grant_o}, 0);
    chk("rst_exc", {31'b0, rsp_exc_o}, 0);
    chk("rst_cause", {30'b0, rsp_cause_o}, 0);
    chk("rst_viol_valid", {31'b0, viol_valid_o}, 0);
    chk("rst_viol_addr", {20'b0, viol_addr_o}, 0);
    chk("rst_viol_cnt", {30'b0, viol_cnt_o}, 0);

    // Supervisor window, user read denied, machine write granted
    cfg_write(0, 'h060, 'h06F, 1, 0, 0);
    do_access(0, 0, 'h064, 0, 0, 0);
    do_access(1, 3, 'h064, 0, 0, 0);
    // Read-only user window
    cfg_write(1, 'h100, 'h1FF, 0, 1, 0);
    do_access(1, 1, 'h180, 0, 0, 0);
    do_access(0, 1, 'h180, 0, 0, 0);
    // Unmatched address and reserved privilege
    do_access(0, 1, 'h300, 0, 0, 0);
    do_access(0, 3, 'h300, 0, 0, 0);
    do_access(0, 2, 'h300, 0, 0, 0);
    // Overlap: range0 (min S, writable) must win over range2 (min U, read-only)
    cfg_write(2, 'h050, 'h070, 0, 1, 0);
    do_access(0, 0, 'h065, 0, 0, 0);
    do_access(1, 1, 'h065, 0, 0, 0);
    do_access(1, 1, 'h055, 0, 0, 0);
    // Lock range0, attempted reprogram ignored, response held for 3 cycles
    cfg_write(0, 'h060, 'h06F, 1, 0, 1);
    cfg_write(0, 'h060, 'h06F, 0, 0, 0);
    do_access(0, 0, 'h064, 3, 0, 0);
    // Inverted window never matches
    cfg_write(3, 'h500, 'h400, 0, 0, 0);
    do_access(0, 0, 'h480, 0, 0, 0);
    // Config write on the CHECK edge is not seen by that check
    cfg_write(3, 'h400, 'h4FF, 3, 0, 0);
    mc_idx = 3; mc_base = 'h400; mc_limit = 'h4FF; mc_minp = 0; mc_ro = 0; mc_lock = 0;
    do_access(0, 0, 'h450, 0, 0, 1);
    do_access(0, 0, 'h450, 0, 0, 0);
    // Clear alone, then saturate, then clear merged with a violation
    do_access(0, 3, 'h300, 0, 1, 0);
    do_access(0, 1, 'h310, 0, 0, 0);
    do_access(0, 1, 'h320, 1, 0, 0);
    do_access(0, 0, 'h330, 0, 0, 0);
    do_access(0, 2, 'h340, 0, 0, 0);
    do_access(0, 1, 'h350, 0, 0, 0);
    do_access(0, 1, 'h360, 0, 1, 0);

    // Randomized accesses with occasional reconfiguration and clears
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = int'($urandom_range(0, 'h6FF));
        cfg_write(int'($urandom_range(0, NR - 1)), b, b + int'($urandom_range(0, 'h180)) - 'h20,
                  int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 7) == 0));
      end
      do_access(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 'h7FF)),
                int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), 0);
    end

    // Make sure the log is non-empty, then reset while a response is pending
    do_access(0, 2, 'h123, 0, 0, 0);
    req_valid_i = 1; req_write_i = 0; req_priv_i = 0; req_addr_i = 'h064;
    @(posedge clk_i); #1;
    req_valid_i = 0;
    @(posedge clk_i); #1;
    chk("pre_reset_resp", {31'b0, rsp_valid_o}, 1);
    rst_ni = 0;
    #1;
    model_reset();
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid_o}, 0);
    chk("mid_rst_exc", {31'b0, rsp_exc_o}, 0);
    chk("mid_rst_cause", {30'b0, rsp_cause_o}, 0);
    chk("mid_rst_viol_valid", {31'b0, viol_valid_o}, 0);
    chk("mid_rst_viol_cnt", {30'b0, viol_cnt_o}, 0);
    chk("mid_rst_viol_addr", {20'b0, viol_addr_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    rsp_ready_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      chk("post_rst_ready", {31'b0, req_ready_o}, 1);
      chk("post_rst_no_rsp", {31'b0, rsp_valid_o}, 0);
    end
    rsp_ready_i = 0;
    // Ranges disabled and unlocked again
    do_access(0, 0, 'h064, 0, 0, 0);
    cfg_write(0, 'h060, 'h06F, 0, 0, 0);
    do_access(0, 0, 'h064, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
